// File: rtl/mem_arb_pkg.sv
// =============================================================================
// Module : mem_arb_pkg
// Brief  : Shared state encoding, port ids and word size for the memory arbiter.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_e;

    localparam logic PORT_I     = 1'b0;
    localparam logic PORT_D     = 1'b1;
    localparam int   WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// =============================================================================
// Module : mem_arb_rr
// Brief  : Two-way combinational round-robin picker; on a tie the port that
//          did not win last time is chosen.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_id,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        gnt_id  = PORT_I;
        if (&req) begin
            gnt_id = ~last_gnt;
        end else if (req[PORT_D]) begin
            gnt_id = PORT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// =============================================================================
// Module : mem_arbiter
// Brief  : Shares one backing-memory port between icache line refills (burst)
//          and dcache single-beat accesses. Optional ack timeout abort is
//          enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        i_done,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_done,
    output logic        d_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int                  c_BEAT_W    = $clog2(BURST_LEN);
    localparam logic [31:0]         c_LINE_MASK = ~(32'(BURST_LEN * WORD_BYTES) - 32'd1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

    arb_state_e          r_state, w_state_nxt;
    logic [c_BEAT_W-1:0] r_beat, w_beat_nxt;
    logic                r_last_gnt, w_last_gnt_nxt;
    logic [31:0]         r_base, w_base_nxt;
    logic                r_we, w_we_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;
    logic                w_gnt_id;
    logic                w_gnt_vld;
    logic                w_abort;

    mem_arb_rr u_rr (
        .req      ({d_req, i_req}),
        .last_gnt (r_last_gnt),
        .gnt_id   (w_gnt_id),
        .gnt_vld  (w_gnt_vld)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    logic [c_WAIT_W-1:0] r_wait;

    // Idle cycles hold the counter at zero, so every grant starts fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (r_state == IDLE || mem_ack) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign w_abort = (r_state != IDLE) && (r_wait == c_WAIT_W'(TIMEOUT));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_last_gnt <= PORT_D;
            r_base     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat     <= w_beat_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_base     <= w_base_nxt;
            r_we       <= w_we_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_nxt     = r_beat;
        w_last_gnt_nxt = r_last_gnt;
        w_base_nxt     = r_base;
        w_we_nxt       = r_we;
        w_wdata_nxt    = r_wdata;
        mem_req        = 1'b0;
        mem_addr       = '0;
        mem_we         = 1'b0;
        mem_wdata      = '0;
        i_rdata        = '0;
        i_valid        = 1'b0;
        i_done         = 1'b0;
        i_err          = 1'b0;
        d_rdata        = '0;
        d_valid        = 1'b0;
        d_done         = 1'b0;
        d_err          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_last_gnt_nxt = w_gnt_id;
                    if (w_gnt_id == PORT_I) begin
                        w_base_nxt  = i_addr & c_LINE_MASK;
                        w_beat_nxt  = '0;
                        w_state_nxt = GNT_I;
                    end else begin
                        w_base_nxt  = d_addr;
                        w_we_nxt    = d_we;
                        w_wdata_nxt = d_wdata;
                        w_state_nxt = GNT_D;
                    end
                end
            end

            GNT_I: begin
                if (w_abort) begin
                    i_done      = 1'b1;
                    i_err       = 1'b1;
                    w_beat_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = r_base + 32'(r_beat) * 32'(WORD_BYTES);
                    if (mem_ack) begin
                        i_valid    = 1'b1;
                        i_rdata    = mem_rdata;
                        w_beat_nxt = r_beat + 1'b1;
                        if (r_beat == c_LAST_BEAT) begin
                            i_done      = 1'b1;
                            w_beat_nxt  = '0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end

            GNT_D: begin
                if (w_abort) begin
                    d_done      = 1'b1;
                    d_err       = 1'b1;
                    w_beat_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    mem_req   = 1'b1;
                    mem_addr  = r_base;
                    mem_we    = r_we;
                    mem_wdata = r_wdata;
                    if (mem_ack) begin
                        d_valid     = 1'b1;
                        d_done      = 1'b1;
                        d_rdata     = mem_rdata;
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
